piso_transmitter: RTL
=====================

PISO_TRANSMITTER -- requirements
Module: piso_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the frame length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 1'b0, giving the SO value whenever no frame is being shifted.
REQ-003 C  input  1  single clock; all state SHALL change on posedge C only.
REQ-004 CLR  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 D  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-006 LOAD  input  1  load request; held by the source until accepted.
REQ-007 READY  output  1  block can accept a word this cycle.
REQ-008 SO  output  1  serial data out, MSB first.
REQ-009 FRAME  output  1  high while SO carries valid frame bits.
REQ-010 DONE  output  1  one-cycle pulse after each completed frame.

Function
REQ-011 The FSM SHALL have two states, IDLE and SHIFT, plus a WIDTH-bit shift register SR and a bit counter CNT of ceil(log2(WIDTH)) bits.
REQ-012 A load SHALL be accepted on a posedge C where LOAD=1 and READY=1; LOAD while READY=0 SHALL be ignored, with no state change.
REQ-013 READY SHALL be combinational: 1 in IDLE; 1 in SHIFT only when CNT=WIDTH-1; else 0.
REQ-014 On accept: SR<=D, CNT<=0, state<=SHIFT.
REQ-015 Latency: the first bit (D[WIDTH-1]) SHALL appear on SO in the cycle immediately after the accepting edge.
REQ-016 In SHIFT, SO SHALL equal SR[WIDTH-1] and FRAME SHALL be 1; in IDLE, SO=IDLE_LEVEL and FRAME=0.
REQ-017 In SHIFT with CNT<WIDTH-1, each edge SHALL apply SR<=SR<<1 (zero fill) and CNT<=CNT+1.
REQ-018 In SHIFT with CNT=WIDTH-1 and no accept, the edge SHALL apply state<=IDLE and CNT<=0.
REQ-019 In SHIFT with CNT=WIDTH-1 and an accept, the edge SHALL apply REQ-014, so frames stream back-to-back with no idle bit and FRAME stays 1.
REQ-020 Each frame SHALL occupy exactly WIDTH cycles of FRAME=1, transmitting D[WIDTH-1] down to D[0].
REQ-021 DONE SHALL be registered and equal 1 for exactly the one cycle after each edge at which CNT=WIDTH-1 in SHIFT, including back-to-back frames.
REQ-022 D changes while not accepting SHALL NOT affect SO.
REQ-023 A receiver that shifts left with SI into bit 0 on the same posedge C SHALL hold the transmitted word in its WIDTH-bit register after WIDTH edges.

Reset
REQ-024 CLR=1 SHALL immediately, independent of C, force state=IDLE, SR=0, CNT=0, DONE=0, SO=IDLE_LEVEL, FRAME=0 and READY=1.
REQ-025 CLR asserted mid-frame SHALL abort the frame with no DONE; the partial word SHALL NOT resume after release.
REQ-026 The first posedge C after CLR deasserts SHALL behave as IDLE, accepting a pending LOAD.

Verification
REQ-027 Reset then LOAD=1, D=8'hA5 for one cycle -> SO over 8 cycles = 1,0,1,0,0,1,0,1; FRAME=1 for 8 cycles; DONE=1 in the 9th; READY=0 cycles 1-7.
REQ-028 D=8'h3C then D=8'hFF with LOAD held continuously -> 16 contiguous FRAME=1 cycles, SO=00111100 11111111, DONE pulses after bit 8 and bit 16.
REQ-029 LOAD pulsed with D=8'h00 in frame cycle 3 of an 8'hF0 frame -> ignored; SO=11110000 unchanged; block returns to IDLE after 8 bits.
REQ-030 CLR pulsed asynchronously between edges at bit 4 of 8'h81 -> SO=0, FRAME=0, READY=1 at once; no DONE; next LOAD with D=8'h81 sends a full 10000001.
REQ-031 Transmitter SO/C wired to an 8-bit left-shift SI/C receiver, random D for 1000 words -> receiver register equals D on every DONE cycle.
REQ-032 WIDTH=16, IDLE_LEVEL=1, D=16'h8001 -> SO=1 in idle, then 1, fourteen 0s, 1; DONE after 16 bits; SO returns to 1.

Source files
------------

// File: rtl/piso_transmitter_if.sv
// ---------------------------------------------------------------------------
// piso_transmitter_if
// Parallel-load / serial-out link between a word source and the transmitter.
//
// Signals:
//   D      source -> transmitter   parallel word, sampled only on accept
//   LOAD   source -> transmitter   load request, held until accepted
//   READY  transmitter -> source   a word can be accepted this cycle
//   SO     transmitter -> line     serial data, MSB first
//   FRAME  transmitter -> line     high while SO carries frame bits
//   DONE   transmitter -> source   one-cycle pulse after each frame
//
// Modports:
//   master  the word source / line observer side
//   slave   the transmitter side
// ---------------------------------------------------------------------------
interface piso_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             LOAD;
    logic             READY;
    logic             SO;
    logic             FRAME;
    logic             DONE;

    modport master (
        output D,
        output LOAD,
        input  READY,
        input  SO,
        input  FRAME,
        input  DONE
    );

    modport slave (
        input  D,
        input  LOAD,
        output READY,
        output SO,
        output FRAME,
        output DONE
    );
endinterface

// File: rtl/piso_transmitter.sv
// ---------------------------------------------------------------------------
// piso_transmitter
// Loads a WIDTH-bit word on a LOAD/READY handshake and shifts it out MSB
// first on SO, one bit per clock. A new word may be accepted during the last
// bit of the current frame, so frames can stream with no idle gap.
//
// Parameters:
//   WIDTH       frame length in bits (2..32)
//   IDLE_LEVEL  SO value whenever no frame is being shifted
//
// Ports:
//   C    clock, all state changes on its rising edge
//   CLR  asynchronous active-high reset
//   bus  handshake and serial outputs (slave side of piso_transmitter_if)
// ---------------------------------------------------------------------------
module piso_transmitter #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                 C,
    input  logic                 CLR,
    piso_transmitter_if.slave    bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             done_q;

    logic             last_bit;
    logic             ready;
    logic             accept;

    // The last bit of a frame is the only point inside SHIFT where a new word
    // can be taken; that is what lets back-to-back frames run without a gap.
    always_comb begin
        last_bit = (state == SHIFT) && (cnt == LAST);
        ready    = (state == IDLE) || last_bit;
        accept   = bus.LOAD && ready;
    end

    // State, shift register and bit counter. An accept has priority over the
    // end-of-frame return to IDLE so the next frame starts on the very next
    // cycle. The register is not shifted on the last bit since SO leaves SR
    // at that point anyway.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (accept) begin
                sr    <= bus.D;
                cnt   <= '0;
                state <= SHIFT;
            end else if (state == SHIFT) begin
                if (last_bit) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    sr  <= sr << 1;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.READY = ready;
        bus.FRAME = (state == SHIFT);
        bus.SO    = (state == SHIFT) ? sr[WIDTH-1] : IDLE_LEVEL;
        bus.DONE  = done_q;
    end

endmodule
